prog_clock_divider: RTL

//  Multi-channel, run-time programmable clock divider; parametrised successor of the fixed divide-by-2 board divider.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_channel.sv | 88 ++++++++
 rtl/prog_clock_divider.sv | 89 ++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_pkg
// Purpose  : Shared constants and types for the programmable clock divider.
//            MIN_DIV is the smallest ratio a channel may run at, and
//            CNT_W_DEF is the default divisor/counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int MIN_DIV   = 2;
    localparam int CNT_W_DEF = 16;

    typedef logic [CNT_W_DEF-1:0] div_t;

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_channel
// Purpose  : One divider channel. It holds the period counter, the shadow
//            ratio (written by the load path), the active ratio (used by the
//            counter) and the registered clk/tick outputs.
// Ports    : board_clock - sole clock, posedge
//            reset       - asynchronous, active-high
//            enable      - run enable for this channel
//            wr_en       - write wr_value into the shadow ratio
//            wr_value    - already-clamped ratio (>= MIN_DIV)
//            clk         - divided clock, registered
//            tick        - one-cycle strobe marking phase 0 of each period
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = MIN_DIV
) (
    input  logic             board_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_value,
    output logic             clk,
    output logic             tick
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_clk;
    logic             r_tick;

    logic [CNT_W:0]   w_half;
    logic             w_high;
    logic             w_wrap;

    // ceil(N/2) in one extra bit so N = 2**CNT_W-1 cannot overflow.
    assign w_half = ({1'b0, r_active} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    assign w_high = ({1'b0, r_cnt} < w_half);
    // active is never below MIN_DIV, so active-1 cannot underflow.
    assign w_wrap = (r_cnt == (r_active - 1'b1));

    // The outputs decode the counter value present at the edge, so the first
    // enabled edge emits phase 0 (clk=1, tick=1) straight from the held cnt=0.
    always_ff @(posedge board_clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_active <= c_default_div;
            r_shadow <= c_default_div;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            if (wr_en) begin
                r_shadow <= wr_value;
            end
            if (!enable) begin
                // Idle: counter parked at phase 0, new ratio taken immediately.
                r_cnt    <= '0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
                r_active <= r_shadow;
            end else begin
                r_clk  <= w_high;
                r_tick <= (r_cnt == '0);
                if (w_wrap) begin
                    // Period boundary: the shadow value read here is the one
                    // from before any same-edge write, so a load coinciding
                    // with the wrap takes effect one period later.
                    r_cnt    <= '0;
                    r_active <= r_shadow;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign clk  = r_clk;
    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Purpose  : Multi-channel run-time programmable clock divider. Produces
//            NUM_CH divided clocks and matching tick strobes from board_clock.
//            Ratios are reprogrammed through a load handshake and applied at
//            period boundaries so no runt or stretched pulse is produced.
// Ports    : board_clock - sole clock, posedge
//            reset       - asynchronous, active-high
//            enable      - [NUM_CH] per-channel run enable
//            div_load    - load request pulse
//            div_ch      - [CH_W] channel addressed by div_load
//            div_value   - [CNT_W] requested ratio
//            div_ack     - pulse: load accepted (valid channel)
//            div_err     - pulse: ratio clamped or channel out of range
//            clk         - [NUM_CH] divided clocks
//            tick        - [NUM_CH] strobe on each rising edge of clk[i]
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int CH_W        = 1,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              board_clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              div_load,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_value,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] clk,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] c_min_div = CNT_W'(MIN_DIV);
    localparam logic [31:0]      c_num_ch  = 32'(NUM_CH);

    logic [31:0]       w_ch_idx;
    logic              w_ch_ok;
    logic              w_clamp;
    logic [CNT_W-1:0]  w_wr_value;
    logic [NUM_CH-1:0] w_wr_en;
    logic              r_ack;
    logic              r_err;

    assign w_ch_idx   = 32'(div_ch);
    assign w_ch_ok    = (w_ch_idx < c_num_ch);
    assign w_clamp    = (div_value < c_min_div);
    assign w_wr_value = w_clamp ? c_min_div : div_value;

    always_ff @(posedge board_clock or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= div_load & w_ch_ok;
            r_err <= div_load & (~w_ch_ok | w_clamp);
        end
    end

    assign div_ack = r_ack;
    assign div_err = r_err;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_wr_en[i] = div_load & w_ch_ok & (w_ch_idx == 32'(i));

            clkdiv_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .board_clock (board_clock),
                .reset       (reset),
                .enable      (enable[i]),
                .wr_en       (w_wr_en[i]),
                .wr_value    (w_wr_value),
                .clk         (clk[i]),
                .tick        (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
